// File: rtl/prog_loader.sv
// prog_loader -- writer side of the program-memory interface.
//
// Fills program memory from a nibble stream. Each program byte arrives as two
// nibbles, instr (high) first and then oprnd (low). Bytes are written at an
// auto-incrementing address that wraps modulo 2^AW. While a load is running,
// cpu_hold keeps the PC/fetch stage stalled.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   When defined, two more nibbles (hi, lo) follow the last byte. They carry
//   the expected modulo-256 sum of all written bytes. chk_err reports a
//   mismatch at the end of the load, stays valid until the next start or
//   reset, and is cleared on start.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   start      in   begin a load (honoured only when idle)
//   base_addr  in   AW   first write address, captured on start
//   count      in   AW+1 byte count 0..2^AW, captured on start
//   nib_valid  in   nibble source has data
//   nib_in     in   DW/2 nibble data
//   nib_ready  out  loader accepts a nibble this cycle
//   mem_we     out  one-cycle write strobe
//   mem_addr   out  AW write address (holds the last written address)
//   mem_wdata  out  DW write data {hi, lo}
//   busy       out  load in progress
//   cpu_hold   out  same as busy
//   done       out  one-cycle pulse at the end of a load
//   chk_err    out  checksum mismatch (only with PROG_LOADER_CHECKSUM_EN)
module prog_loader #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  input  logic          nib_valid,
  input  logic [DW/2-1:0] nib_in,
  output logic          nib_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          cpu_hold,
  output logic          done
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic          chk_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WR,
    S_DONE
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    S_CHK_HI,
    S_CHK_LO
`endif
  } state_t;

  state_t          state;
  logic [AW-1:0]   addr;       // next address to write
  logic [AW:0]     remaining;  // bytes still to write, including the current one
  logic [DW/2-1:0] hi_nib;     // instr nibble waiting for its oprnd partner

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DW-1:0]   sum;        // running modulo-2^DW sum of written bytes
  logic            chk_ok;     // received checksum matched sum
`endif

  // All outputs are registered and assigned together with the state change,
  // so each output's value always matches the state the FSM is in.
  // busy is the registered form of (state != S_IDLE).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      hi_nib    <= '0;
      nib_ready <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum       <= '0;
      chk_ok    <= 1'b0;
      chk_err   <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= count;
            busy      <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum       <= '0;
            chk_err   <= 1'b0;
            nib_ready <= 1'b1;
            // An empty load still collects a checksum, expected to be zero.
            state     <= (count == '0) ? S_CHK_HI : S_HI;
`else
            if (count == '0) begin
              state <= S_DONE;
            end else begin
              state     <= S_HI;
              nib_ready <= 1'b1;
            end
`endif
          end
        end

        S_HI: begin
          if (nib_valid && nib_ready) begin
            hi_nib <= nib_in;
            state  <= S_LO;
          end
        end

        S_LO: begin
          if (nib_valid && nib_ready) begin
            mem_wdata <= {hi_nib, nib_in};
            mem_addr  <= addr;
            mem_we    <= 1'b1;
            nib_ready <= 1'b0;
            state     <= S_WR;
          end
        end

        // The write strobe is high for exactly this one cycle. The address
        // and remaining count advance only as the state leaves S_WR, so
        // mem_addr/mem_wdata stay stable while mem_we is high.
        S_WR: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum       <= sum + mem_wdata;
`endif
          if (remaining == {{AW{1'b0}}, 1'b1}) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state     <= S_CHK_HI;
            nib_ready <= 1'b1;
`else
            state     <= S_DONE;
`endif
          end else begin
            state     <= S_HI;
            nib_ready <= 1'b1;
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK_HI: begin
          if (nib_valid && nib_ready) begin
            hi_nib <= nib_in;
            state  <= S_CHK_LO;
          end
        end

        S_CHK_LO: begin
          if (nib_valid && nib_ready) begin
            chk_ok    <= ({hi_nib, nib_in} == sum);
            nib_ready <= 1'b0;
            state     <= S_DONE;
          end
        end
`endif

        // done is raised here, so it is visible in the first idle cycle.
        // busy drops at the same edge.
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
`ifdef PROG_LOADER_CHECKSUM_EN
          chk_err <= ~chk_ok;
`endif
        end

        default: begin
          state     <= S_IDLE;
          nib_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_hold = busy;

endmodule
